glitch_seq: RTL and testbench



---
 rtl/glitch_seq.sv | 214 +++++++++++++++++++++
 tb/tb_glitch_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/glitch_seq.sv
// ---------------------------------------------------------------------------
// glitch_seq -- parametrised clock-glitch sequencer
//
// After an arm the configuration is latched into shadow registers and the
// block waits for a rising trigger edge. It then counts `delay` clk cycles,
// raises the registered glitch enable for max(width,1) cycles, and repeats
// that pulse max(count,1) times separated by `gap` idle cycles. While the
// enable is high the target clock is replaced according to the latched mode.
//
// Optional build macro:
//   GLITCH_TRIG_SYNC_EN  - pass trig through a two-flop synchroniser before
//                          edge detection (adds 2 cycles of trigger latency).
//
// Parameters:
//   CNT_W  width of the delay/width/gap counters
//   NUM_W  width of the pulse-count field
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   clk_in   in   target clock to be glitched (treated as data)
//   trig     in   external trigger, rising-edge active
//   arm      in   latch configuration and wait for trigger (ignored when busy)
//   abort    in   cancel a running sequence
//   delay    in   [CNT_W] trigger-to-first-pulse delay
//   width    in   [CNT_W] pulse length
//   gap      in   [CNT_W] cycles between pulses
//   count    in   [NUM_W] number of pulses (0 treated as 1)
//   mode     in   [4]     glitch mode, bit3 > bit2 > bit1 > bit0
//   clk_out  out  glitched clock
//   en_out   out  registered glitch enable
//   busy     out  high whenever the sequencer is not idle
//   done     out  one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module glitch_seq #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             trig,
    input  logic             arm,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [NUM_W-1:0] count,
    input  logic [3:0]       mode,
    output logic             clk_out,
    output logic             en_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
    logic [NUM_W-1:0] r_rem, w_nxt_rem;
    logic [CNT_W-1:0] r_delay, r_width, r_gap;
    logic [3:0]       r_mode;
    logic             r_en, r_done, r_trig_prev;
    logic             w_trig, w_trig_edge, w_latch, w_nxt_done;
    logic [CNT_W-1:0] w_width_eff;
    logic             w_clk_out;

`ifdef GLITCH_TRIG_SYNC_EN
    logic r_trig_s1, r_trig_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
        end else begin
            r_trig_s1 <= trig;
            r_trig_s2 <= r_trig_s1;
        end
    end

    assign w_trig = r_trig_s2;
`else
    assign w_trig = trig;
`endif

    assign w_trig_edge = w_trig & ~r_trig_prev;
    // A zero width still produces a single-cycle pulse.
    assign w_width_eff = (r_width == '0) ? CNT_W'(1) : r_width;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_rem   = r_rem;
        w_latch     = 1'b0;
        w_nxt_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_latch     = 1'b1;
                    w_nxt_state = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_trig_edge) begin
                    if (r_delay == '0) begin
                        w_nxt_state = S_PULSE;
                        w_nxt_cnt   = w_width_eff;
                    end else begin
                        w_nxt_state = S_DELAY;
                        w_nxt_cnt   = r_delay;
                    end
                end
            end
            S_DELAY: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_nxt_state = S_PULSE;
                    w_nxt_cnt   = w_width_eff;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (r_cnt <= CNT_W'(1)) begin
                    if (r_rem > NUM_W'(1)) begin
                        w_nxt_rem = r_rem - NUM_W'(1);
                        // gap=0 re-enters PULSE directly, merging the pulses.
                        if (r_gap == '0) begin
                            w_nxt_state = S_PULSE;
                            w_nxt_cnt   = w_width_eff;
                        end else begin
                            w_nxt_state = S_GAP;
                            w_nxt_cnt   = r_gap;
                        end
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_cnt   = '0;
                        w_nxt_done  = 1'b1;
                    end
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_nxt_state = S_PULSE;
                    w_nxt_cnt   = w_width_eff;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        // Abort overrides everything, including the completing transition.
        if (abort && (r_state != S_IDLE)) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_delay     <= '0;
            r_width     <= '0;
            r_gap       <= '0;
            r_mode      <= '0;
            r_en        <= 1'b0;
            r_done      <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_rem       <= w_nxt_rem;
            r_en        <= (w_nxt_state == S_PULSE);
            r_done      <= w_nxt_done;
            r_trig_prev <= w_trig;
            if (w_latch) begin
                r_delay <= delay;
                r_width <= width;
                r_gap   <= gap;
                r_mode  <= mode;
                r_rem   <= (count == '0) ? NUM_W'(1) : count;
            end
        end
    end

    // Glitch selection, highest mode bit wins.
    always_comb begin
        w_clk_out = clk_in;
        if (r_en) begin
            if (r_mode[3])      w_clk_out = 1'b1;
            else if (r_mode[2]) w_clk_out = ~clk_in;
            else if (r_mode[1]) w_clk_out = 1'b1;
            else if (r_mode[0]) w_clk_out = clk_in;
        end
    end

    assign clk_out = w_clk_out;
    assign en_out  = r_en;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_glitch_seq.sv
module tb_glitch_seq;

    localparam int CNT_W = 16;
    localparam int NUM_W = 8;
`ifdef GLITCH_TRIG_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, clk_in, trig, arm, abort;
    logic [CNT_W-1:0] delay, width, gap;
    logic [NUM_W-1:0] count;
    logic [3:0]       mode;
    logic             clk_out, en_out, busy, done;

    int n_vec = 0;
    int n_err = 0;

    glitch_seq #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .trig(trig), .arm(arm),
        .abort(abort), .delay(delay), .width(width), .gap(gap), .count(count),
        .mode(mode), .clk_out(clk_out), .en_out(en_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks clk_out for both clk_in levels given whether the glitch is active
    // and which replacement value the active mode should produce.
    task automatic chk_clk(input string tag, input logic act, input int kind);
        logic e0, e1;
        e0 = 1'b0; e1 = 1'b1;
        if (act) begin
            if (kind == 1) begin e0 = 1'b1; e1 = 1'b0; end
            else if (kind == 2) begin e0 = 1'b1; e1 = 1'b1; end
        end
        clk_in = 1'b0; #1; chk({tag, "_ci0"}, clk_out, e0);
        clk_in = 1'b1; #1; chk({tag, "_ci1"}, clk_out, e1);
        clk_in = 1'b0;
    endtask

    task automatic arm_cfg(input int d, input int w, input int g, input int c,
                           input logic [3:0] m, input string tag);
        delay = CNT_W'(d); width = CNT_W'(w); gap = CNT_W'(g);
        count = NUM_W'(c); mode = m;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk({tag, "_busy_after_arm"}, busy, 1'b1);
    endtask

    task automatic finish_trig();
        trig = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0; clk_in = 1'b0; trig = 1'b0; arm = 1'b0; abort = 1'b0;
        delay = '0; width = '0; gap = '0; count = '0; mode = '0;
        repeat (3) tick();
        chk("rst_en", en_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk_clk("rst_clk", 1'b0, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Scenario 1: delay=3 width=2 gap=0 count=1 mode=0100
        arm_cfg(3, 2, 0, 1, 4'b0100, "s1");
        trig = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("s1_en_c%0d", k), en_out, (k >= 4+S && k <= 5+S));
            chk($sformatf("s1_done_c%0d", k), done, (k == 6+S));
            chk_clk($sformatf("s1_clk_c%0d", k), (k >= 4+S && k <= 5+S), 1);
        end
        chk("s1_busy_end", busy, 1'b0);
        finish_trig();

        // Scenario 2: delay=0 width=1 gap=2 count=3
        arm_cfg(0, 1, 2, 3, 4'b0001, "s2");
        trig = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("s2_en_c%0d", k), en_out,
                (k == 1+S || k == 4+S || k == 7+S));
            chk($sformatf("s2_done_c%0d", k), done, (k == 8+S));
            if (k >= 1+S) chk($sformatf("s2_busy_c%0d", k), busy, (k <= 7+S));
            chk_clk($sformatf("s2_clk_c%0d", k), 1'b0, 0);
        end
        finish_trig();

        // Scenario 3: abort in the second gap of a count=4 run
        arm_cfg(0, 1, 2, 4, 4'b0100, "s3");
        trig = 1'b1;
        for (int k = 1; k <= 5+S; k++) tick();
        chk("s3_in_gap_en", en_out, 1'b0);
        chk("s3_in_gap_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s3_abort_busy", busy, 1'b0);
        chk("s3_abort_en", en_out, 1'b0);
        chk("s3_abort_done", done, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("s3_after_en_%0d", k), en_out, 1'b0);
            chk($sformatf("s3_after_done_%0d", k), done, 1'b0);
        end
        finish_trig();
        arm_cfg(2, 1, 0, 1, 4'b0100, "s3b");
        trig = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("s3b_en_c%0d", k), en_out, (k == 3+S));
            chk($sformatf("s3b_done_c%0d", k), done, (k == 4+S));
        end
        finish_trig();

        // Scenario 4: config changes and arm while busy are ignored
        arm_cfg(2, 3, 1, 2, 4'b0100, "s4");
        trig = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) begin
                delay = '0; width = CNT_W'(1); gap = '0; count = NUM_W'(5); mode = 4'b0000;
            end
            arm = (k == 2);
            tick();
            chk($sformatf("s4_en_c%0d", k), en_out,
                ((k >= 3+S && k <= 5+S) || (k >= 7+S && k <= 9+S)));
            chk($sformatf("s4_done_c%0d", k), done, (k == 10+S));
            chk($sformatf("s4_busy_c%0d", k), busy, (k <= 9+S));
            chk_clk($sformatf("s4_clk_c%0d", k),
                ((k >= 3+S && k <= 5+S) || (k >= 7+S && k <= 9+S)), 1);
        end
        arm = 1'b0;
        finish_trig();

        // Scenario 5: width=0 count=0 gives one 1-cycle pulse, mode bit3 wins
        arm_cfg(1, 0, 3, 0, 4'b1010, "s5");
        trig = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("s5_en_c%0d", k), en_out, (k == 2+S));
            chk($sformatf("s5_done_c%0d", k), done, (k == 3+S));
            chk_clk($sformatf("s5_clk_c%0d", k), (k == 2+S), 2);
        end
        finish_trig();

        // Scenario 6: reset asserted mid-pulse
        arm_cfg(0, 4, 0, 1, 4'b0100, "s6");
        trig = 1'b1;
        for (int k = 1; k <= 2+S; k++) tick();
        chk("s6_pre_en", en_out, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("s6_rst_en", en_out, 1'b0);
        chk("s6_rst_busy", busy, 1'b0);
        chk("s6_rst_done", done, 1'b0);
        chk_clk("s6_rst_clk", 1'b0, 0);
        rst_n = 1'b1;
        tick();
        chk("s6_post_done", done, 1'b0);
        chk("s6_post_busy", busy, 1'b0);
        finish_trig();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
